// File: rtl/fp_addsub_seq_if.sv
// Operand/result handshake bundle for fp_addsub_seq.
// Both channels are valid/ready: a word moves on a rising edge where valid and ready are high.
interface fp_addsub_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] para1;
  logic [W-1:0] para2;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         under_overflow;

  modport master (
    output in_valid, para1, para2, op, out_ready,
    input  in_ready, out_valid, out, under_overflow
  );

  modport slave (
    input  in_valid, para1, para2, op, out_ready,
    output in_ready, out_valid, out, under_overflow
  );
endinterface

// File: rtl/fp_addsub_seq.sv
// Multi-cycle parametrised floating-point add/subtract, round toward zero, denormals flushed.
// Pipeline of states: ALIGN -> ADD -> NORM (1+ cycles) -> PACK -> DONE; specials wait in SPEC.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_addsub_seq_if.slave    bus,
  output logic [2:0]        o_dbg_state
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int M  = MAN_W + 5;
  localparam int EW = EXP_W + 1;
  localparam logic [EW-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EW-1:0] SH_MAX  = EW'(MAN_W + 3);
  localparam logic [EW-1:0] EXP_ONE = EW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    PACK  = 3'd4,
    DONE  = 3'd5,
    SPEC  = 3'd6
  } state_t;

  state_t         r_state;
  logic           r_sa, r_sb;
  logic [EW-1:0]  r_ea, r_eb;
  logic [M-1:0]   r_ma, r_mb;
  logic           r_special;
  logic [W-1:0]   r_spec_word;
  logic [1:0]     r_cnt;
  logic           r_uf;

  // Operand unpack (B's sign already carries op)
  logic [EXP_W-1:0] w_ea_f, w_eb_f;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_sbe;
  logic             w_a_spec, w_b_spec, w_a_nan, w_b_nan;
  logic [M-1:0]     w_ma_in, w_mb_in;
  logic [W-1:0]     w_spec_word;

  assign w_ea_f   = bus.para1[W-2:MAN_W];
  assign w_eb_f   = bus.para2[W-2:MAN_W];
  assign w_fa     = bus.para1[MAN_W-1:0];
  assign w_fb     = bus.para2[MAN_W-1:0];
  assign w_sbe    = bus.para2[W-1] ^ bus.op;
  assign w_a_spec = &w_ea_f;
  assign w_b_spec = &w_eb_f;
  assign w_a_nan  = w_a_spec && (|w_fa);
  assign w_b_nan  = w_b_spec && (|w_fb);
  assign w_ma_in  = (w_ea_f == '0) ? '0 : {2'b01, w_fa, 3'b000};
  assign w_mb_in  = (w_eb_f == '0) ? '0 : {2'b01, w_fb, 3'b000};

  always_comb begin
    w_spec_word = '0;
    if (w_a_nan || w_b_nan || (w_a_spec && w_b_spec && (bus.para1[W-1] != w_sbe)))
      w_spec_word = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    else if (w_a_spec)
      w_spec_word = {bus.para1[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else
      w_spec_word = {w_sbe, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end

  // Alignment: larger magnitude becomes A, smaller is shifted right with sticky collection
  logic           w_swap;
  logic           w_big_s, w_sml_s;
  logic [EW-1:0]  w_big_e, w_sml_e, w_diff;
  logic [M-1:0]   w_big_m, w_sml_m, w_shifted, w_sml_al;
  logic           w_lost;

  assign w_swap    = {r_eb, r_mb} > {r_ea, r_ma};
  assign w_big_s   = w_swap ? r_sb : r_sa;
  assign w_sml_s   = w_swap ? r_sa : r_sb;
  assign w_big_e   = w_swap ? r_eb : r_ea;
  assign w_sml_e   = w_swap ? r_ea : r_eb;
  assign w_big_m   = w_swap ? r_mb : r_ma;
  assign w_sml_m   = w_swap ? r_ma : r_mb;
  assign w_diff    = w_big_e - w_sml_e;
  assign w_shifted = w_sml_m >> w_diff;
  assign w_lost    = |(w_sml_m & ~({M{1'b1}} << w_diff));
  assign w_sml_al  = (w_diff > SH_MAX) ? {{(M-1){1'b0}}, |w_sml_m}
                                       : {w_shifted[M-1:1], w_shifted[0] | w_lost};

  logic [M-1:0] w_sum;
  assign w_sum = (r_sa == r_sb) ? (r_ma + r_mb) : (r_ma - r_mb);

  assign bus.in_ready = (r_state == IDLE) && rst_n;
  assign o_dbg_state  = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state            <= IDLE;
      r_sa               <= 1'b0;
      r_sb               <= 1'b0;
      r_ea               <= '0;
      r_eb               <= '0;
      r_ma               <= '0;
      r_mb               <= '0;
      r_special          <= 1'b0;
      r_spec_word        <= '0;
      r_cnt              <= '0;
      r_uf               <= 1'b0;
      bus.out            <= '0;
      bus.out_valid      <= 1'b0;
      bus.under_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_sa        <= bus.para1[W-1];
            r_sb        <= w_sbe;
            r_ea        <= {1'b0, w_ea_f};
            r_eb        <= {1'b0, w_eb_f};
            r_ma        <= w_ma_in;
            r_mb        <= w_mb_in;
            r_special   <= w_a_spec || w_b_spec;
            r_spec_word <= w_spec_word;
            r_cnt       <= '0;
            r_uf        <= 1'b0;
            r_state     <= (w_a_spec || w_b_spec) ? SPEC : ALIGN;
          end
        end
        // Specials idle here so their latency matches a one-cycle NORM
        SPEC: begin
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd2) r_state <= PACK;
        end
        ALIGN: begin
          r_sa    <= w_big_s;
          r_sb    <= w_sml_s;
          r_ea    <= w_big_e;
          r_ma    <= w_big_m;
          r_mb    <= w_sml_al;
          r_state <= ADD;
        end
        ADD: begin
          r_ma    <= w_sum;
          r_sa    <= (w_sum == '0) ? 1'b0 : r_sa;
          r_state <= NORM;
        end
        NORM: begin
          if (r_ma[M-1]) begin
            r_ma    <= {1'b0, r_ma[M-1:2], r_ma[1] | r_ma[0]};
            r_ea    <= r_ea + EXP_ONE;
            r_state <= PACK;
          end else if (r_ma == '0) begin
            r_state <= PACK;
          end else if (!r_ma[M-2]) begin
            if (r_ea <= EXP_ONE) begin
              r_uf    <= 1'b1;
              r_state <= PACK;
            end else begin
              r_ma <= {r_ma[M-2:0], 1'b0};
              r_ea <= r_ea - EXP_ONE;
            end
          end else begin
            r_state <= PACK;
          end
        end
        PACK: begin
          if (r_special) begin
            bus.out            <= r_spec_word;
            bus.under_overflow <= 1'b0;
          end else if (r_uf) begin
            bus.out            <= {r_sa, {(W-1){1'b0}}};
            bus.under_overflow <= 1'b1;
          end else if (r_ea >= EXP_MAX) begin
            bus.out            <= {r_sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            bus.under_overflow <= 1'b1;
          end else if (r_ma == '0) begin
            bus.out            <= '0;
            bus.under_overflow <= 1'b0;
          end else begin
            bus.out            <= {r_sa, r_ea[EXP_W-1:0], r_ma[M-3:3]};
            bus.under_overflow <= 1'b0;
          end
          bus.out_valid <= 1'b1;
          r_state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq (FP32 configuration) with a result/flag/latency scoreboard.
module tb_fp_addsub_seq;
  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic        uo_q[$];
  int          lat_q[$];

  fp_addsub_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called #1 after a rising edge with the unit idle; returns #1 after the accept edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic o,
                      input bit push, input logic [31:0] e_out, input logic e_uo,
                      input int e_lat);
    chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    bus.para1    = a;
    bus.para2    = b;
    bus.op       = o;
    bus.in_valid = 1'b1;
    if (push) begin
      exp_q.push_back(e_out);
      uo_q.push_back(e_uo);
      lat_q.push_back(e_lat);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.para1    = $urandom;
    bus.para2    = $urandom;
    bus.op       = 1'($urandom_range(0, 1));
  endtask

  task automatic collect(input int hold);
    int          lat;
    logic [31:0] e_out;
    logic        e_uo;
    int          e_lat;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e_out = exp_q.pop_front();
    e_uo  = uo_q.pop_front();
    e_lat = lat_q.pop_front();
    chk("out_valid_seen", {31'd0, bus.out_valid}, 32'd1);
    chk("result", bus.out, e_out);
    chk("under_overflow", {31'd0, bus.under_overflow}, {31'd0, e_uo});
    chk("latency", 32'(lat), 32'(e_lat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_result", bus.out, e_out);
      chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("valid_drop", {31'd0, bus.out_valid}, 32'd0);
    chk("in_ready_back", {31'd0, bus.in_ready}, 32'd1);
    chk("result_kept", bus.out, e_out);
  endtask

  initial begin
    bit seen_valid;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.para1     = '0;
    bus.para2     = '0;
    bus.op        = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", bus.out, 32'h0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_uo", {31'd0, bus.under_overflow}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(32'h3F800000, 32'h40000000, 1'b0, 1, 32'h40400000, 1'b0, 4);
    collect($urandom_range(0, 3));
    send(32'h3F800000, 32'h3F800000, 1'b1, 1, 32'h00000000, 1'b0, 4);
    collect($urandom_range(0, 3));
    send(32'h3F800001, 32'h3F800000, 1'b1, 1, 32'h34000000, 1'b0, 27);
    collect($urandom_range(0, 3));
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1, 32'h7F800000, 1'b1, 4);
    collect($urandom_range(0, 3));
    send(32'h7F800000, 32'h7F800000, 1'b1, 1, 32'h7FC00000, 1'b0, 4);
    collect($urandom_range(0, 3));
    send(32'hFF800000, 32'h3F800000, 1'b0, 1, 32'hFF800000, 1'b0, 4);
    collect($urandom_range(0, 3));
    // 2.0 - 1.0 needs one left shift; 1.0 + -1.0 cancels; NaN propagates; tiny difference underflows
    send(32'h40000000, 32'h3F800000, 1'b1, 1, 32'h3F800000, 1'b0, 5);
    collect($urandom_range(0, 3));
    send(32'h3F800000, 32'hBF800000, 1'b0, 1, 32'h00000000, 1'b0, 4);
    collect($urandom_range(0, 3));
    send(32'h7FC00000, 32'h3F800000, 1'b0, 1, 32'h7FC00000, 1'b0, 4);
    collect($urandom_range(0, 3));
    send(32'h00800001, 32'h00800000, 1'b1, 1, 32'h00000000, 1'b1, 4);
    collect($urandom_range(0, 3));

    send(32'h3F800000, 32'h40000000, 1'b0, 1, 32'h40400000, 1'b0, 4);
    collect(10);

    send(32'h3F800001, 32'h3F800000, 1'b1, 0, 32'h0, 1'b0, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_norm_state", {29'd0, dbg_state}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("in_ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_out", bus.out, 32'h0);
    chk("abort_state", {29'd0, dbg_state}, 32'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen_valid = 1'b1;
    end
    chk("abort_no_output", {31'd0, seen_valid}, 32'd0);

    send(32'h3F800000, 32'h40000000, 1'b0, 1, 32'h40400000, 1'b0, 4);
    collect($urandom_range(0, 3));

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
